regfile_writeback_arbiter: RTL and testbench
============================================

Name: regfile_writeback_arbiter

Overview:
- Drives the single write port of the datapath register file: rfw_enable, rfw_address3 and rfw_data3.
- Merges two result sources onto that port:
  - the ALU, which is single-cycle and never back-pressured;
  - the load/memory path, which is valid/ready handshaked.
- Load results that lose arbitration wait in a DEPTH-entry FIFO.
- Exposes read-hazard flags so the decode stage can stall reads of registers with pending writes.

Parameters:
DEPTH, 4, load FIFO entries; power of two, >= 2
PTR_W, 2, log2(DEPTH); derived, not overridden

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
alu_valid  input  1  ALU result present this cycle
alu_rd  input  5  ALU destination register
alu_data  input  32  ALU result
ld_valid  input  1  load result offered
ld_ready  output  1  load result accepted when ld_valid && ld_ready
ld_rd  input  5  load destination register
ld_data  input  32  load result
rfr_address1  input  5  decode read address 1 (same net as register-file port)
rfr_address2  input  5  decode read address 2
haz1  output  1  pending write to rfr_address1
haz2  output  1  pending write to rfr_address2
rfw_enable  output  1  register-file write enable (registered)
rfw_address3  output  5  register-file write address (registered)
rfw_data3  output  32  register-file write data (registered)
pending_count  output  PTR_W+1  live-or-killed FIFO occupancy

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - rfw_enable=0, rfw_address3=0, rfw_data3=0.
  - FIFO empty, pending_count=0, all kill bits clear.
  - ld_ready=0 while rst=1.
- Reset mid-operation: reset discards queued loads and any in-flight write.
- Back-pressure: ld_ready = !full && !rst (combinational). A full FIFO back-pressures even if the ALU is idle.
- Writes to r0:
  - A result with rd==0 is accepted (consumes the handshake) and discarded.
  - It never asserts rfw_enable and is never enqueued.
- Per-cycle arbitration, evaluated in priority order. The selected write is registered onto the rfw_* outputs at the next edge (latency 1 cycle).
  1. alu_valid && alu_rd!=0: issue the ALU write.
  2. Else FIFO non-empty: pop the head. Issue it if live; if killed, pop it with rfw_enable=0.
  3. Else, a load accepted this cycle with ld_rd!=0 bypasses the FIFO and issues directly.
  4. Else rfw_enable=0 next cycle. rfw_address3 and rfw_data3 hold their last values.
- Enqueue: an accepted load (ld_rd!=0) not issued via step 3 is pushed at the tail.
  - Push and pop in the same cycle is legal when full: the pop frees a slot.
  - ld_ready still reflects the pre-pop full state.
- Write-after-write ordering:
  - Queued entries are older than any ALU result. An issued ALU write to rd X clears the live bit of every queued entry with rd==X.
  - A load accepted in the same cycle as an ALU write to the same rd is younger. It is enqueued live and not killed.
- Hazard flags, combinational:
  - haz1 = rfr_address1!=0 && (a live FIFO entry has rd==rfr_address1, or (rfw_enable && rfw_address3==rfr_address1)).
  - haz2 is the same for rfr_address2.
  - The in-flight term is needed because the register file writes on the same edge that decode samples.
- Pointers: PTR_W-bit read and write pointers wrap modulo DEPTH; full/empty are derived from pending_count.

Test Plan:
- Reset check: hold rst 2 cycles with ld_valid=1 -> ld_ready=0 and rfw_enable=0. Release -> ld_ready=1, pending_count=0.
- ALU beats load:
  - Stimulus: cycle 0 ALU rd=5 data=0x11111111 plus load rd=6 data=0x22222222.
  - Required: cycle 1 rfw_enable=1 addr=5 data=0x11111111. Cycle 2 addr=6 data=0x22222222. pending_count 0->1->0.
- Fill and backpressure:
  - Stimulus: ALU valid rd=1 every cycle; offer 5 loads rd=10..14.
  - Required: after 4 accepts ld_ready=0 and pending_count=4. Drop alu_valid -> loads drain in order rd=10,11,12,13, then 14 is accepted.
- Kill:
  - Stimulus: queue load rd=7 data=0xAAAA behind ALU traffic, then ALU rd=7 data=0xBBBB.
  - Required: register 7 ends at 0xBBBB. The killed entry pops with rfw_enable=0, and haz for address 7 drops once the ALU write retires.
- r0 discard: ALU rd=0 and load rd=0 -> no rfw_enable pulse, pending_count stays 0, load handshake completes.
- Hazard:
  - Stimulus: queued live load rd=9, rfr_address1=9, rfr_address2=0.
  - Required: haz1=1, haz2=0. haz1 stays 1 during the cycle rfw_address3=9 with rfw_enable=1, then goes to 0.

Source files
------------

// File: rtl/regfile_writeback_arbiter.sv
// Register-file writeback arbiter.
// Merges a single-cycle ALU result stream and a valid/ready load stream onto
// the single register-file write port. Loads that lose arbitration wait in a
// small FIFO. A later ALU write to the same register kills the queued loads
// that target it, which keeps write-after-write order intact. Combinational
// hazard flags tell decode which read addresses still have a write pending.
module regfile_writeback_arbiter #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  // ALU result: single cycle, never back-pressured
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [31:0]      alu_data,
  // Load result: valid/ready handshake
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [4:0]       ld_rd,
  input  logic [31:0]      ld_data,
  // Decode read addresses and their hazard flags
  input  logic [4:0]       rfr_address1,
  input  logic [4:0]       rfr_address2,
  output logic             haz1,
  output logic             haz2,
  // Register-file write port
  output logic             rfw_enable,
  output logic [4:0]       rfw_address3,
  output logic [31:0]      rfw_data3,
  // FIFO occupancy, counting live and killed entries
  output logic [PTR_W:0]   pending_count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  // FIFO storage. A set live bit means the entry still has to be written.
  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] live_q;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  logic full;
  logic empty;
  logic ld_accept;
  logic ld_nonzero;
  logic alu_issue;
  logic pop;
  logic bypass;
  logic push;

  // Occupancy flags and the arbitration decision for this cycle.
  always_comb begin
    full       = (pending_count == FULL_COUNT);
    empty      = (pending_count == '0);
    // ld_ready is taken from the occupancy before any pop this cycle, so a
    // full FIFO back-pressures even while it is draining.
    ld_ready   = !full && !rst;
    ld_accept  = ld_valid && ld_ready;
    // A load to r0 still completes its handshake but carries no write.
    ld_nonzero = ld_accept && (ld_rd != 5'd0);
    alu_issue  = alu_valid && (alu_rd != 5'd0);
    pop        = !alu_issue && !empty;
    bypass     = !alu_issue && empty && ld_nonzero;
    push       = ld_nonzero && !bypass;
  end

  // Hazard detection: any live queued write or the write in flight this cycle.
  always_comb begin
    logic hit1;
    logic hit2;
    hit1 = 1'b0;
    hit2 = 1'b0;
    // Popped and killed entries have their live bit cleared, so a live bit
    // alone marks an occupied entry that still has to be written.
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (rd_q[i] == rfr_address1)) hit1 = 1'b1;
      if (live_q[i] && (rd_q[i] == rfr_address2)) hit2 = 1'b1;
    end
    // The in-flight term covers the edge where the register file is written
    // at the same moment that decode samples it.
    if (rfw_enable && (rfw_address3 == rfr_address1)) hit1 = 1'b1;
    if (rfw_enable && (rfw_address3 == rfr_address2)) hit2 = 1'b1;
    haz1 = (rfr_address1 != 5'd0) && hit1;
    haz2 = (rfr_address2 != 5'd0) && hit2;
  end

  // FIFO payload storage. Only the live bits need a reset value.
  always_ff @(posedge clk) begin
    // NOTE: the rd/data arrays are left out of reset on purpose. An entry is
    // only read after a push has written it, so resetting it would add reset
    // fan-out and gain nothing.
    if (!rst && push) begin
      rd_q[wr_ptr]   <= ld_rd;
      data_q[wr_ptr] <= ld_data;
    end
  end

  // FIFO control: pointers, occupancy, live bits and kill on ALU writes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. The kill
    // loop and the push below both target live_q. The later push assignment
    // wins, so a load that arrives with a same-rd ALU write stays live.
    if (rst) begin
      live_q        <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      pending_count <= '0;
    end else begin
      if (alu_issue) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (rd_q[i] == alu_rd) live_q[i] <= 1'b0;
        end
      end
      if (pop) begin
        live_q[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + 1'b1;
      end
      if (push) begin
        live_q[wr_ptr] <= 1'b1;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   pending_count <= pending_count + 1'b1;
        2'b01:   pending_count <= pending_count - 1'b1;
        default: pending_count <= pending_count;
      endcase
    end
  end

  // Registered write port: one cycle after the arbitration decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rfw_enable   <= 1'b0;
      rfw_address3 <= 5'd0;
      rfw_data3    <= 32'd0;
    end else if (alu_issue) begin
      rfw_enable   <= 1'b1;
      rfw_address3 <= alu_rd;
      rfw_data3    <= alu_data;
    end else if (pop) begin
      // A killed head is popped with no write. Address and data keep their
      // last values.
      rfw_enable <= live_q[rd_ptr];
      if (live_q[rd_ptr]) begin
        rfw_address3 <= rd_q[rd_ptr];
        rfw_data3    <= data_q[rd_ptr];
      end
    end else if (bypass) begin
      rfw_enable   <= 1'b1;
      rfw_address3 <= ld_rd;
      rfw_data3    <= ld_data;
    end else begin
      rfw_enable <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Testbench for regfile_writeback_arbiter.
// A queue-based reference model holds the pending loads, the expected write
// port and the expected register-file contents. Directed scenarios run first,
// then randomized traffic.
module tb_regfile_writeback_arbiter;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             alu_valid;
  logic [4:0]       alu_rd;
  logic [31:0]      alu_data;
  logic             ld_valid;
  logic             ld_ready;
  logic [4:0]       ld_rd;
  logic [31:0]      ld_data;
  logic [4:0]       rfr_address1;
  logic [4:0]       rfr_address2;
  logic             haz1;
  logic             haz2;
  logic             rfw_enable;
  logic [4:0]       rfw_address3;
  logic [31:0]      rfw_data3;
  logic [PTR_W:0]   pending_count;

  regfile_writeback_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .rfr_address1(rfr_address1), .rfr_address2(rfr_address2),
    .haz1(haz1), .haz2(haz2),
    .rfw_enable(rfw_enable), .rfw_address3(rfw_address3), .rfw_data3(rfw_data3),
    .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          live;
  } entry_t;

  // Reference model state
  entry_t      q[$];
  bit          m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_rf  [32];
  logic [31:0] dut_rf[32];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_haz(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].live && q[i].rd == a) return 1'b1;
    return m_en && (m_addr == a);
  endfunction

  // Drive one cycle of inputs, check the combinational outputs, let the model
  // and the DUT both advance by one edge, then check the registered outputs.
  task automatic step(input bit r, input bit av, input logic [4:0] ard, input logic [31:0] adat,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ldat,
                      input logic [4:0] a1, input logic [4:0] a2);
    bit exp_ready;
    bit acc;
    entry_t e;
    @(negedge clk);
    rst = r; alu_valid = av; alu_rd = ard; alu_data = adat;
    ld_valid = lv; ld_rd = lrd; ld_data = ldat;
    rfr_address1 = a1; rfr_address2 = a2;
    #1;
    exp_ready = !r && (q.size() < DEPTH);
    check("ld_ready", 32'(ld_ready), 32'(exp_ready));
    if (!r) begin
      check("haz1", 32'(haz1), 32'(model_haz(a1)));
      check("haz2", 32'(haz2), 32'(model_haz(a2)));
    end
    acc = lv && exp_ready;
    if (r) begin
      q.delete();
      m_en = 0; m_addr = '0; m_data = '0;
    end else if (av && ard != 0) begin
      // The ALU result is younger than every queued load, so it kills them.
      foreach (q[i]) if (q[i].rd == ard) q[i].live = 0;
      m_en = 1; m_addr = ard; m_data = adat;
      if (acc && lrd != 0) q.push_back('{lrd, ldat, 1'b1});
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_en = e.live;
      if (e.live) begin m_addr = e.rd; m_data = e.data; end
      if (acc && lrd != 0) q.push_back('{lrd, ldat, 1'b1});
    end else if (acc && lrd != 0) begin
      m_en = 1; m_addr = lrd; m_data = ldat;
    end else begin
      m_en = 0;
    end
    if (m_en) m_rf[m_addr] = m_data;
    @(posedge clk);
    #1;
    if (rfw_enable) dut_rf[rfw_address3] = rfw_data3;
    check("rfw_enable", 32'(rfw_enable), 32'(m_en));
    check("rfw_address3", 32'(rfw_address3), 32'(m_addr));
    check("rfw_data3", rfw_data3, m_data);
    check("pending_count", 32'(pending_count), 32'(q.size()));
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    step(0, 0, 0, 0, 0, 0, 0, a1, a2);
  endtask

  initial begin
    foreach (m_rf[i]) begin m_rf[i] = '0; dut_rf[i] = '0; end
    m_en = 0; m_addr = '0; m_data = '0;
    rst = 1; alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0; rfr_address1 = 0; rfr_address2 = 0;

    // Reset held two cycles with a load offered: never accepted.
    step(1, 0, 0, 0, 1, 3, 32'h33, 0, 0);
    step(1, 0, 0, 0, 1, 3, 32'h33, 0, 0);
    idle(0, 0);
    check("ready_after_reset", 32'(ld_ready), 32'd1);

    // ALU beats load; the load follows one cycle later from the FIFO.
    step(0, 1, 5, 32'h11111111, 1, 6, 32'h22222222, 0, 0);
    check("alu_first_addr", 32'(rfw_address3), 32'd5);
    check("alu_first_pc", 32'(pending_count), 32'd1);
    idle(0, 0);
    check("load_second_addr", 32'(rfw_address3), 32'd6);
    check("load_second_data", rfw_data3, 32'h22222222);

    // Fill and back-pressure: continuous ALU traffic queues four loads.
    for (int i = 0; i < 4; i++)
      step(0, 1, 1, 32'h100 + i, 1, 5'(10 + i), 32'hA0 + i, 0, 0);
    check("fill_pc", 32'(pending_count), 32'd4);
    step(0, 1, 1, 32'h200, 1, 14, 32'hAE, 0, 0);
    // ALU stops; the queue drains in order and rd=14 gets in behind it.
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 14, 32'hAE, 0, 0);
    for (int i = 0; i < 3; i++) idle(0, 0);
    check("drain_rf14", dut_rf[14], 32'hAE);
    check("drain_rf13", dut_rf[13], 32'hA3);

    // Kill: a queued load to r7 is overtaken by an ALU write to r7.
    step(0, 1, 1, 32'h1, 1, 7, 32'hAAAA, 7, 0);
    step(0, 1, 7, 32'hBBBB, 0, 0, 0, 7, 0);
    idle(7, 0);
    idle(7, 0);
    check("kill_rf7", dut_rf[7], 32'hBBBB);
    check("kill_haz_clear", 32'(haz1), 32'd0);

    // Writes to r0 are discarded on both sources.
    step(0, 1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 0, 0);
    check("r0_no_write", 32'(rfw_enable), 32'd0);

    // Hazard on a queued live load to r9, through to its retirement.
    step(0, 1, 1, 32'h5, 1, 9, 32'h99, 9, 0);
    idle(9, 0);
    idle(9, 0);
    idle(9, 0);
    check("haz_retired", 32'(haz1), 32'd0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
